// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU interrupt/reset entry sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_H,
    ST_PUSH_L,
    ST_PUSH_P,
    ST_VEC_L,
    ST_VEC_H,
    ST_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    SRC_RST,
    SRC_NMI,
    SRC_BRK,
    SRC_IRQ
  } seq_src_t;

  localparam logic [15:0] VEC_NMI_DEF    = 16'hFFFA;
  localparam logic [15:0] VEC_RST_DEF    = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_DEF    = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE_DEF = 8'h01;

  localparam int unsigned P_C = 0;
  localparam int unsigned P_Z = 1;
  localparam int unsigned P_I = 2;
  localparam int unsigned P_D = 3;
  localparam int unsigned P_B = 4;
  localparam int unsigned P_U = 5;
  localparam int unsigned P_V = 6;
  localparam int unsigned P_N = 7;

  function automatic logic [7:0] push_status(input logic [7:0] p, input logic is_brk);
    logic [7:0] r;
    r      = p;
    r[P_U] = 1'b1;
    r[P_B] = is_brk;
    return r;
  endfunction

endpackage

// File: rtl/cpu_nmi_edge.sv
// NMI input: 2-flop synchroniser followed by a falling-edge pulse.
//   clk, reset : clock, synchronous active-high reset
//   nmi_n      : asynchronous NMI pin, active-low
//   nmi_fall   : one-cycle pulse per synchronised high-to-low transition
module cpu_nmi_edge (
  input  logic clk,
  input  logic reset,
  input  logic nmi_n,
  output logic nmi_fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[1:0], nmi_n};
  end

  assign nmi_fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/cpu_irq_sequencer.sv
// 6502-style RESET/NMI/BRK/IRQ entry sequencer with N maskable IRQ lines.
//   Inputs : clk, reset, irq_n, irq_mask, nmi_n, brk_req, instr_boundary,
//            i_flag, pc_in, p_in, sp_in, rdy, rd_data
//   Outputs: bus_addr, bus_wdata, bus_we, bus_rd, busy, pc_load, new_pc,
//            sp_out, set_i, irq_src, reset_out
module cpu_irq_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned N_IRQ      = 4,
  parameter logic [15:0] VEC_NMI    = VEC_NMI_DEF,
  parameter logic [15:0] VEC_RST    = VEC_RST_DEF,
  parameter logic [15:0] VEC_IRQ    = VEC_IRQ_DEF,
  parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq_n,
  input  logic [N_IRQ-1:0]  irq_mask,
  input  logic              nmi_n,
  input  logic              brk_req,
  input  logic              instr_boundary,
  input  logic              i_flag,
  input  logic [15:0]       pc_in,
  input  logic [7:0]        p_in,
  input  logic [7:0]        sp_in,
  input  logic              rdy,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_rd,
  output logic              busy,
  output logic              pc_load,
  output logic [15:0]       new_pc,
  output logic [7:0]        sp_out,
  output logic              set_i,
  output logic [N_IRQ-1:0]  irq_src,
  output logic              reset_out
);

  seq_state_t  state, state_nxt;
  seq_src_t    src, accept_src;
  logic        accept;
  logic        rst_pend, nmi_pend, nmi_fall;
  logic        irq_any, is_push, hijack, commit_nmi;
  logic [15:0] pc_q, vec_q, vec_sel;
  logic [7:0]  p_q, sp_q, p_push;
  logic [N_IRQ-1:0] irq_act;

  cpu_nmi_edge u_nmi_edge (
    .clk      (clk),
    .reset    (reset),
    .nmi_n    (nmi_n),
    .nmi_fall (nmi_fall)
  );

  assign irq_act = ~irq_n & irq_mask;
  assign irq_any = (|irq_act) && !i_flag;
  assign is_push = (state == ST_PUSH_H) || (state == ST_PUSH_L) || (state == ST_PUSH_P);
  assign p_push  = push_status(p_q, src == SRC_BRK);
  assign busy    = (state != ST_IDLE);

  // The vector is chosen on the PUSH_P -> VEC_L edge; an edge pulse in PUSH_P
  // counts as pending so a late NMI still hijacks the BRK/IRQ vector.
  assign hijack     = nmi_pend | nmi_fall;
  assign commit_nmi = (state == ST_PUSH_P) && rdy && (src != SRC_RST)
                      && ((src == SRC_NMI) || hijack);

  always_comb begin
    if (src == SRC_RST)                     vec_sel = VEC_RST;
    else if ((src == SRC_NMI) || hijack)    vec_sel = VEC_NMI;
    else                                    vec_sel = VEC_IRQ;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    accept_src = SRC_IRQ;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_we     = 1'b0;
    bus_rd     = 1'b0;
    pc_load    = 1'b0;
    set_i      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rst_pend) begin
          accept = 1'b1; accept_src = SRC_RST;
        end else if (instr_boundary) begin
          if (nmi_pend) begin
            accept = 1'b1; accept_src = SRC_NMI;
          end else if (brk_req) begin
            accept = 1'b1; accept_src = SRC_BRK;
          end else if (irq_any) begin
            accept = 1'b1; accept_src = SRC_IRQ;
          end
        end
        if (!rdy) accept = 1'b0;
        if (accept) state_nxt = ST_PUSH_H;
      end
      ST_PUSH_H, ST_PUSH_L, ST_PUSH_P: begin
        bus_addr = ADDR_W'({STACK_PAGE, sp_q});
        if (src == SRC_RST) begin
          bus_rd = 1'b1;
        end else begin
          bus_we = 1'b1;
          case (state)
            ST_PUSH_H: bus_wdata = DATA_W'(pc_q[15:8]);
            ST_PUSH_L: bus_wdata = DATA_W'(pc_q[7:0]);
            default:   bus_wdata = DATA_W'(p_push);
          endcase
        end
        if (rdy) begin
          case (state)
            ST_PUSH_H: state_nxt = ST_PUSH_L;
            ST_PUSH_L: state_nxt = ST_PUSH_P;
            default:   state_nxt = ST_VEC_L;
          endcase
        end
      end
      ST_VEC_L: begin
        bus_addr = ADDR_W'(vec_q);
        bus_rd   = 1'b1;
        if (rdy) state_nxt = ST_VEC_H;
      end
      ST_VEC_H: begin
        bus_addr = ADDR_W'(vec_q + 16'd1);
        bus_rd   = 1'b1;
        if (rdy) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        pc_load = rdy;
        set_i   = rdy;
        if (rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      src       <= SRC_RST;
      rst_pend  <= 1'b1;
      reset_out <= 1'b1;
      nmi_pend  <= 1'b0;
      pc_q      <= '0;
      p_q       <= '0;
      sp_q      <= '0;
      vec_q     <= '0;
      new_pc    <= '0;
      sp_out    <= '0;
      irq_src   <= '0;
    end else begin
      state <= state_nxt;
      if (commit_nmi)    nmi_pend <= 1'b0;
      else if (nmi_fall) nmi_pend <= 1'b1;
      if (accept) begin
        src    <= accept_src;
        pc_q   <= pc_in;
        p_q    <= p_in;
        sp_q   <= sp_in;
        sp_out <= sp_in - 8'd3;
        if (accept_src == SRC_IRQ) irq_src <= irq_act;
      end
      if (is_push && rdy) sp_q <= sp_q - 8'd1;
      if ((state == ST_PUSH_P) && rdy) vec_q <= vec_sel;
      if ((state == ST_VEC_L) && rdy) new_pc[7:0]  <= rd_data[7:0];
      if ((state == ST_VEC_H) && rdy) new_pc[15:8] <= rd_data[7:0];
      if ((state == ST_DONE) && rdy && (src == SRC_RST)) begin
        rst_pend  <= 1'b0;
        reset_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_irq_sequencer.sv
// Directed bench for cpu_irq_sequencer with a small vector-memory model.
module tb_cpu_irq_sequencer;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset, nmi_n, brk_req, instr_boundary, i_flag, rdy;
  logic [3:0]  irq_n, irq_mask, irq_src;
  logic [15:0] pc_in, bus_addr, new_pc;
  logic [7:0]  p_in, sp_in, rd_data, bus_wdata, sp_out;
  logic        bus_we, bus_rd, busy, pc_load, set_i, reset_out;

  xfer_t       log_q[$];
  int          total = 0, bad = 0;
  int          pl_cnt = 0, busy_cycles = 0, n, pl_start;
  logic [15:0] pl_pc;
  logic [7:0]  pl_sp;
  logic        pl_seti;

  always #5 clk = ~clk;

  cpu_irq_sequencer #(.ADDR_W(16), .DATA_W(8), .N_IRQ(4)) dut (
    .clk(clk), .reset(reset), .irq_n(irq_n), .irq_mask(irq_mask),
    .nmi_n(nmi_n), .brk_req(brk_req), .instr_boundary(instr_boundary),
    .i_flag(i_flag), .pc_in(pc_in), .p_in(p_in), .sp_in(sp_in), .rdy(rdy),
    .rd_data(rd_data), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_rd(bus_rd), .busy(busy), .pc_load(pc_load),
    .new_pc(new_pc), .sp_out(sp_out), .set_i(set_i), .irq_src(irq_src),
    .reset_out(reset_out)
  );

  always_comb begin
    case (bus_addr)
      16'hFFFA: rd_data = 8'h00;
      16'hFFFB: rd_data = 8'hA0;
      16'hFFFC: rd_data = 8'h34;
      16'hFFFD: rd_data = 8'h12;
      16'hFFFE: rd_data = 8'h00;
      16'hFFFF: rd_data = 8'h90;
      default:  rd_data = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_xfer(input string tag, input int idx, input logic we,
                            input logic [15:0] a, input logic [7:0] d);
    logic [31:0] got;
    got = (idx < log_q.size()) ? 32'(log_q[idx]) : 32'hFFFF_FFFF;
    check(tag, got, {7'd0, we, a, d});
  endtask

  task automatic step();
    @(negedge clk);
    if (rdy && (bus_we || bus_rd))
      log_q.push_back(xfer_t'{bus_we, bus_addr, bus_we ? bus_wdata : rd_data});
    if (busy) busy_cycles++;
    if (pc_load) begin
      pl_cnt++;
      pl_pc   = new_pc;
      pl_sp   = sp_out;
      pl_seti = set_i;
    end
    #1;
  endtask

  task automatic run_seq(output int cnt);
    int start;
    start = pl_cnt;
    cnt   = 0;
    while (pl_cnt == start && cnt < 30) begin
      step();
      cnt++;
    end
  endtask

  task automatic check_reset_seq();
    check_xfer("rst_x0", 0, 1'b0, 16'h0100, 8'h00);
    check_xfer("rst_x1", 1, 1'b0, 16'h01FF, 8'h00);
    check_xfer("rst_x2", 2, 1'b0, 16'h01FE, 8'h00);
    check_xfer("rst_x3", 3, 1'b0, 16'hFFFC, 8'h34);
    check_xfer("rst_x4", 4, 1'b0, 16'hFFFD, 8'h12);
    check("rst_nxfer", log_q.size(), 5);
    check("rst_pc", pl_pc, 16'h1234);
    check("rst_sp", pl_sp, 8'hFD);
    check("rst_seti", pl_seti, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rdy = 1'b1; irq_n = '1; irq_mask = '0; nmi_n = 1'b1;
    brk_req = 1'b0; instr_boundary = 1'b0; i_flag = 1'b0;
    pc_in = '0; p_in = '0; sp_in = 8'h00;

    // Reset values, then the RESET sequence
    repeat (3) step();
    check("rv_busy", busy, 1'b0);
    check("rv_reset_out", reset_out, 1'b1);
    check("rv_addr", bus_addr, 16'h0000);
    check("rv_strobes", {bus_we, bus_rd, pc_load, set_i}, 4'b0000);
    check("rv_new_pc", new_pc, 16'h0000);
    check("rv_sp_out", sp_out, 8'h00);
    check("rv_irq_src", irq_src, 4'b0000);
    reset = 1'b0;
    log_q.delete();
    run_seq(n);
    check("rst_lat", n, 6);
    check_reset_seq();
    check("rst_out_done", reset_out, 1'b1);
    step();
    check("rst_out_fall", reset_out, 1'b0);
    check("rst_idle", busy, 1'b0);

    // IRQ on line 2; the line drops right after accept
    pc_in = 16'h8003; p_in = 8'h21; sp_in = 8'hFF;
    irq_n = 4'b1011; irq_mask = 4'b0100; instr_boundary = 1'b1;
    log_q.delete();
    step();
    check("irq_busy", busy, 1'b1);
    irq_n = '1; instr_boundary = 1'b0;
    run_seq(n);
    check("irq_lat", n + 1, 6);
    check_xfer("irq_x0", 0, 1'b1, 16'h01FF, 8'h80);
    check_xfer("irq_x1", 1, 1'b1, 16'h01FE, 8'h03);
    check_xfer("irq_x2", 2, 1'b1, 16'h01FD, 8'h21);
    check_xfer("irq_x3", 3, 1'b0, 16'hFFFE, 8'h00);
    check_xfer("irq_x4", 4, 1'b0, 16'hFFFF, 8'h90);
    check("irq_pc", pl_pc, 16'h9000);
    check("irq_sp", pl_sp, 8'hFC);
    check("irq_seti", pl_seti, 1'b1);
    check("irq_src", irq_src, 4'b0100);
    step();

    // Masked by i_flag, then by irq_mask
    irq_n = 4'b1011; irq_mask = 4'b0100; i_flag = 1'b1; instr_boundary = 1'b1;
    busy_cycles = 0;
    repeat (20) step();
    check("mask_iflag", busy_cycles, 0);
    i_flag = 1'b0; irq_mask = 4'b0000;
    repeat (20) step();
    check("mask_line", busy_cycles, 0);
    irq_n = '1; instr_boundary = 1'b0;

    // BRK
    pc_in = 16'hC002; p_in = 8'h20; sp_in = 8'hFD;
    brk_req = 1'b1; instr_boundary = 1'b1;
    log_q.delete();
    step();
    brk_req = 1'b0; instr_boundary = 1'b0;
    run_seq(n);
    check("brk_lat", n + 1, 6);
    check_xfer("brk_x0", 0, 1'b1, 16'h01FD, 8'hC0);
    check_xfer("brk_x1", 1, 1'b1, 16'h01FC, 8'h02);
    check_xfer("brk_x2", 2, 1'b1, 16'h01FB, 8'h30);
    check_xfer("brk_x3", 3, 1'b0, 16'hFFFE, 8'h00);
    check_xfer("brk_x4", 4, 1'b0, 16'hFFFF, 8'h90);
    check("brk_pc", pl_pc, 16'h9000);
    check("brk_sp", pl_sp, 8'hFA);
    step();

    // BRK hijacked by an NMI edge arriving during the pushes
    brk_req = 1'b1; instr_boundary = 1'b1;
    log_q.delete();
    step();
    brk_req = 1'b0; instr_boundary = 1'b0; nmi_n = 1'b0;
    run_seq(n);
    check("hj_lat", n + 1, 6);
    check_xfer("hj_x2", 2, 1'b1, 16'h01FB, 8'h30);
    check_xfer("hj_x3", 3, 1'b0, 16'hFFFA, 8'h00);
    check_xfer("hj_x4", 4, 1'b0, 16'hFFFB, 8'hA0);
    check("hj_pc", pl_pc, 16'hA000);
    step();
    nmi_n = 1'b1; instr_boundary = 1'b1; busy_cycles = 0;
    repeat (8) step();
    check("hj_no_refire", busy_cycles, 0);

    // NMI held low: one sequence, with a 3-cycle stall in VEC_L
    pc_in = 16'h1234; p_in = 8'h34; sp_in = 8'hFA;
    log_q.delete();
    pl_start = pl_cnt;
    nmi_n = 1'b0;
    n = 0;
    while (!busy && n < 10) begin
      step();
      n++;
    end
    check("nmi_acc_lat", n, 4);
    repeat (3) step();
    check("nmi_vecl", {bus_rd, bus_addr}, {1'b1, 16'hFFFA});
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", {bus_rd, pc_load, bus_addr}, {2'b10, 16'hFFFA});
    end
    rdy = 1'b1;
    run_seq(n);
    check("stall_lat", n, 2);
    check_xfer("nmi_x0", 0, 1'b1, 16'h01FA, 8'h12);
    check_xfer("nmi_x1", 1, 1'b1, 16'h01F9, 8'h34);
    check_xfer("nmi_x2", 2, 1'b1, 16'h01F8, 8'h24);
    check_xfer("nmi_x3", 3, 1'b0, 16'hFFFA, 8'h00);
    check_xfer("nmi_x4", 4, 1'b0, 16'hFFFB, 8'hA0);
    check("nmi_nxfer", log_q.size(), 5);
    check("nmi_pc", pl_pc, 16'hA000);
    check("nmi_sp", pl_sp, 8'hF7);
    step();
    busy_cycles = 0;
    repeat (45) step();
    check("nmi_held_busy", busy_cycles, 0);
    check("nmi_held_once", pl_cnt - pl_start, 1);
    nmi_n = 1'b1; instr_boundary = 1'b0;

    // Reset during PUSH_P of an IRQ
    pc_in = 16'h4000; p_in = 8'h00; sp_in = 8'h80;
    irq_n = 4'b1110; irq_mask = 4'b0001; instr_boundary = 1'b1;
    step();
    irq_n = '1; instr_boundary = 1'b0;
    step();
    step();
    check("mid_pushp", {bus_we, bus_addr, bus_wdata}, {1'b1, 16'h017E, 8'h20});
    check("mid_src", irq_src, 4'b0001);
    reset = 1'b1;
    step();
    check("mid_abort", {busy, bus_we, bus_rd, reset_out}, 4'b0001);
    check("mid_addr", bus_addr, 16'h0000);
    check("mid_src_clr", irq_src, 4'b0000);
    sp_in = 8'h00;
    reset = 1'b0;
    log_q.delete();
    run_seq(n);
    check("mid_rst_lat", n, 6);
    check_reset_seq();
    step();
    check("mid_rst_out", reset_out, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
